// File: rtl/fp_mult_rr_sched.sv
// Round-robin scheduler sharing one two-stage signed fixed-point multiplier among NUM_REQ requesters.
// Define FP_MULT_SAT_EN to saturate on overflow and add the sat_flag output.
module fp_mult_rr_sched #(
  parameter int FP_WIDTH = 16,
  parameter int FP_FRAC  = 8,
  parameter int NUM_REQ  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*FP_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*FP_WIDTH-1:0]  req_b,
  input  logic                         stall,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [FP_WIDTH-1:0]          resp_data,
`ifdef FP_MULT_SAT_EN
  output logic                         sat_flag,
`endif
  output logic                         busy
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PROD_W = 2 * FP_WIDTH;
  localparam int MSB    = FP_WIDTH - 1 + FP_FRAC;

  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_any;
  logic [FP_WIDTH-1:0] a_sel;
  logic [FP_WIDTH-1:0] b_sel;

  logic                s1_valid;
  logic [FP_WIDTH-1:0] s1_a;
  logic [FP_WIDTH-1:0] s1_b;
  logic [NUM_REQ-1:0]  s1_tag;

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;
  logic signed [PROD_W-1:0] prod;
  logic [FP_WIDTH-1:0]      res_data;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = rr_ptr;
    req_ready = '0;
    if (!stall && !rst) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!grant_any && req_valid[wrap_add(rr_ptr, k)]) begin
          grant_any = 1'b1;
          grant_idx = wrap_add(rr_ptr, k);
        end
      end
    end
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        a_sel = req_a[i*FP_WIDTH +: FP_WIDTH];
        b_sel = req_b[i*FP_WIDTH +: FP_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= PTR_W'(NUM_REQ - 1);
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else if (!stall) begin
      s1_valid <= grant_any;
      if (grant_any) begin
        rr_ptr <= grant_idx;
        s1_a   <= a_sel;
        s1_b   <= b_sel;
        s1_tag <= req_ready;
      end
    end
  end

  // Operands sign-extended to full product width so the multiply is exact.
  assign a_ext = $signed({{FP_WIDTH{s1_a[FP_WIDTH-1]}}, s1_a});
  assign b_ext = $signed({{FP_WIDTH{s1_b[FP_WIDTH-1]}}, s1_b});
  assign prod  = a_ext * b_ext;

`ifdef FP_MULT_SAT_EN
  logic [PROD_W-1-MSB:0] prod_upper;
  logic                  ovf;
  logic                  res_sat;

  assign prod_upper = prod[PROD_W-1:MSB];
  assign ovf        = !((&prod_upper) || !(|prod_upper));

  always_comb begin
    res_sat  = 1'b0;
    res_data = prod[MSB -: FP_WIDTH];
    if (ovf) begin
      res_sat  = 1'b1;
      res_data = prod[PROD_W-1] ? {1'b1, {(FP_WIDTH-1){1'b0}}}
                                : {1'b0, {(FP_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (!stall && s1_valid) begin
      sat_flag <= res_sat;
    end
  end
`else
  logic unused_prod;

  assign unused_prod = ^prod;
  assign res_data    = prod[MSB -: FP_WIDTH];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= '0;
      resp_data  <= '0;
    end else if (!stall) begin
      resp_valid <= s1_valid ? s1_tag : '0;
      if (s1_valid) resp_data <= res_data;
    end
  end

  assign busy = s1_valid | (|resp_valid);

endmodule

// File: tb/tb_fp_mult_rr_sched.sv
// Scoreboard bench for fp_mult_rr_sched: stimulus pushes expected results, a negedge monitor checks them.
module tb_fp_mult_rr_sched;
  localparam int W = 16;
  localparam int N = 4;

`ifdef FP_MULT_SAT_EN
  localparam logic [W-1:0] E_7F  = 16'h7FFF;
  localparam logic [W-1:0] E_SQ  = 16'h7FFF;
  localparam logic [W-1:0] E_NEG = 16'h8000;
  localparam logic         E_SAT = 1'b1;
`else
  localparam logic [W-1:0] E_7F  = 16'hFE00;
  localparam logic [W-1:0] E_SQ  = 16'h0000;
  localparam logic [W-1:0] E_NEG = 16'h0000;
  localparam logic         E_SAT = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           stall;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_data;
  logic           busy;
`ifdef FP_MULT_SAT_EN
  logic           sat_flag;
`endif

  logic [W-1:0] op_a[N];
  logic [W-1:0] op_b[N];
  logic [W-1:0] base_res[N] = '{16'h0300, 16'h0340, 16'hFF80, 16'h0100};

  typedef struct packed {
    logic [N-1:0] tag;
    logic [W-1:0] data;
    logic         sat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  fp_mult_rr_sched #(.FP_WIDTH(W), .FP_FRAC(8), .NUM_REQ(N)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .stall(stall),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
`ifdef FP_MULT_SAT_EN
    .sat_flag(sat_flag),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] exp_rdy,
                      input logic [W-1:0] exp_data, input logic exp_sat, input bit push);
    exp_t e;
    req_valid = v;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (push && exp_rdy != '0) begin
      e.tag  = exp_rdy;
      e.data = exp_data;
      e.sat  = exp_sat;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    stall = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_base_ops();
    op_a[0] = 16'h0180; op_b[0] = 16'h0200;
    op_a[1] = 16'h0100; op_b[1] = 16'h0340;
    op_a[2] = 16'hFF00; op_b[2] = 16'h0080;
    op_a[3] = 16'h0040; op_b[3] = 16'h0400;
  endtask

  // A held result is checked every cycle but consumed only on a cycle without stall.
  always @(negedge clk) begin
    if (resp_valid != '0) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got tag %b data %h, expected no result at %0t",
                 resp_valid, resp_data, $time);
      end else begin
        mon_e = sb_q[0];
        chk("resp_valid", 32'(resp_valid), 32'(mon_e.tag));
        chk("resp_data", 32'(resp_data), 32'(mon_e.data));
`ifdef FP_MULT_SAT_EN
        chk("sat_flag", 32'(sat_flag), 32'(mon_e.sat));
`endif
        if (!stall) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    req_valid = 4'b1111;
    set_base_ops();

    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_data", 32'(resp_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
`ifdef FP_MULT_SAT_EN
    chk("rst_sat_flag", 32'(sat_flag), 32'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = '0;

    // single op latency and busy profile
    step(4'b0001, 4'b0001, 16'h0300, 1'b0, 1'b1);
    req_valid = '0;
    @(negedge clk);
    chk("lat1_resp_valid", 32'(resp_valid), 32'h0);
    chk("lat1_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("lat2_resp_valid", 32'(resp_valid), 32'h1);
    chk("lat2_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("lat3_resp_valid", 32'(resp_valid), 32'h0);
    chk("lat3_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;

    // full load from reset: 0,1,2,3,0,1,2,3
    do_reset();
    for (int i = 0; i < 8; i++)
      step(4'b1111, 4'b0001 << (i % 4), base_res[i % 4], 1'b0, 1'b1);
    idle(3);

    step(4'b0100, 4'b0100, 16'hFF80, 1'b0, 1'b1);
    idle(2);

    // overflow cases
    op_a[0] = 16'h7F00; op_b[0] = 16'h0200;
    op_a[1] = 16'h8000; op_b[1] = 16'h8000;
    op_a[3] = 16'h8000; op_b[3] = 16'h0200;
    step(4'b0001, 4'b0001, E_7F, E_SAT, 1'b1);
    step(4'b0010, 4'b0010, E_SQ, E_SAT, 1'b1);
    step(4'b1000, 4'b1000, E_NEG, E_SAT, 1'b1);
    idle(3);
    set_base_ops();

    // stream with a three-cycle stall after the first result
    step(4'b1111, 4'b0001, 16'h0300, 1'b0, 1'b1);
    step(4'b1111, 4'b0010, 16'h0340, 1'b0, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step(4'b1111, 4'b0000, '0, 1'b0, 1'b0);
    stall = 1'b0;
    step(4'b1111, 4'b0100, 16'hFF80, 1'b0, 1'b1);
    step(4'b1111, 4'b1000, 16'h0100, 1'b0, 1'b1);
    idle(4);

    // reset right after a transfer drops it and restores requester 0 priority
    step(4'b0010, 4'b0010, '0, 1'b0, 1'b0);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("rst_drop_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_drop_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(4'b1001, 4'b0001, 16'h0300, 1'b0, 1'b1);
    idle(4);

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
